// File: rtl/tpu_sequencer.sv
// PC-driven instruction sequencer for the systolic array: fetch/decode, multi-cycle load/compute strobes, store_req held until store_ack.
// Instructions take 2 cycles (+ARRAY_DIM rows, +N compute beats, +ack wait); SEQ_ILLEGAL_TRAP_EN makes opcode 110 trap instead of acting as NOP.
module tpu_sequencer #(
    parameter int INSTR_W   = 16,
    parameter int ADDR_W    = 13,
    parameter int PC_W      = 8,
    parameter int ARRAY_DIM = 4,
    parameter int CNT_W     = 8,
    localparam int ROW_W    = (ARRAY_DIM > 1) ? $clog2(ARRAY_DIM) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic [PC_W-1:0]    pc,
    input  logic [INSTR_W-1:0] instruction,
    output logic [ADDR_W-1:0]  base_address,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [ROW_W-1:0]   row_idx,
    output logic               load_weight,
    output logic               load_input,
    output logic               compute_en,
    output logic               store_req,
    input  logic               store_ack,
    output logic               busy,
    output logic               done,
    output logic               error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WAIT_ACK,
        S_HALTED
    } state_t;

    localparam logic [2:0] OP_NOP       = 3'b000;
    localparam logic [2:0] OP_LOAD_ADDR = 3'b001;
    localparam logic [2:0] OP_LOAD_WT   = 3'b010;
    localparam logic [2:0] OP_LOAD_IN   = 3'b011;
    localparam logic [2:0] OP_COMPUTE   = 3'b100;
    localparam logic [2:0] OP_STORE     = 3'b101;
    localparam logic [2:0] OP_ILLEGAL   = 3'b110;
    localparam logic [2:0] OP_HALT      = 3'b111;

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ARRAY_DIM - 1);

    state_t             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [ADDR_W-1:0]  base_q, base_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         ir_op_q, ir_op_d;
    logic               lw_q, lw_d;
    logic               li_q, li_d;
    logic               ce_q, ce_d;
    logic               st_q, st_d;
    logic               done_q, done_d;
`ifdef SEQ_ILLEGAL_TRAP_EN
    logic               err_q, err_d;
`endif

    logic [2:0]         opcode;
    logic [ADDR_W-1:0]  operand;
    logic [CNT_W-1:0]   cnt_field;
    logic               last_beat;

    assign opcode    = instruction[INSTR_W-1 -: 3];
    assign operand   = instruction[INSTR_W-4:0];
    assign cnt_field = operand[CNT_W-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            base_q  <= '0;
            row_q   <= '0;
            cnt_q   <= '0;
            ir_op_q <= OP_NOP;
            lw_q    <= 1'b0;
            li_q    <= 1'b0;
            ce_q    <= 1'b0;
            st_q    <= 1'b0;
            done_q  <= 1'b0;
`ifdef SEQ_ILLEGAL_TRAP_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            base_q  <= base_d;
            row_q   <= row_d;
            cnt_q   <= cnt_d;
            ir_op_q <= ir_op_d;
            lw_q    <= lw_d;
            li_q    <= li_d;
            ce_q    <= ce_d;
            st_q    <= st_d;
            done_q  <= done_d;
`ifdef SEQ_ILLEGAL_TRAP_EN
            err_q   <= err_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        base_d    = base_q;
        row_d     = row_q;
        cnt_d     = cnt_q;
        ir_op_d   = ir_op_q;
        lw_d      = lw_q;
        li_d      = li_q;
        ce_d      = ce_q;
        st_d      = st_q;
        done_d    = done_q;
`ifdef SEQ_ILLEGAL_TRAP_EN
        err_d     = err_q;
`endif
        // Load phases end on the last row; compute ends when the beat counter hits zero.
        last_beat = (ir_op_q == OP_COMPUTE) ? (cnt_q == '0) : (row_q == LAST_ROW);

        case (state_q)
            S_IDLE, S_HALTED: begin
                if (start) begin
                    state_d = S_FETCH;
                    pc_d    = '0;
                    done_d  = 1'b0;
`ifdef SEQ_ILLEGAL_TRAP_EN
                    err_d   = 1'b0;
`endif
                end
            end
            S_FETCH: begin
                state_d = S_DECODE;
            end
            S_DECODE: begin
                ir_op_d = opcode;
                case (opcode)
                    OP_LOAD_ADDR: begin
                        base_d  = operand;
                        pc_d    = pc_q + PC_W'(1);
                        state_d = S_FETCH;
                    end
                    OP_LOAD_WT: begin
                        lw_d    = 1'b1;
                        row_d   = '0;
                        state_d = S_EXEC;
                    end
                    OP_LOAD_IN: begin
                        li_d    = 1'b1;
                        row_d   = '0;
                        state_d = S_EXEC;
                    end
                    OP_COMPUTE: begin
                        ce_d    = 1'b1;
                        cnt_d   = (cnt_field == '0) ? '0 : cnt_field - CNT_W'(1);
                        state_d = S_EXEC;
                    end
                    OP_STORE: begin
                        st_d    = 1'b1;
                        state_d = S_WAIT_ACK;
                    end
                    OP_HALT: begin
                        done_d  = 1'b1;
                        state_d = S_HALTED;
                    end
`ifdef SEQ_ILLEGAL_TRAP_EN
                    OP_ILLEGAL: begin
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                        state_d = S_HALTED;
                    end
`endif
                    default: begin
                        pc_d    = pc_q + PC_W'(1);
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_EXEC: begin
                if (last_beat) begin
                    lw_d    = 1'b0;
                    li_d    = 1'b0;
                    ce_d    = 1'b0;
                    row_d   = '0;
                    pc_d    = pc_q + PC_W'(1);
                    state_d = S_FETCH;
                end else if (ir_op_q == OP_COMPUTE) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    row_d = row_q + ROW_W'(1);
                end
            end
            S_WAIT_ACK: begin
                if (store_ack) begin
                    st_d    = 1'b0;
                    pc_d    = pc_q + PC_W'(1);
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign pc           = pc_q;
    assign base_address = base_q;
    assign mem_addr     = base_q + {{(ADDR_W-ROW_W){1'b0}}, row_q};
    assign row_idx      = row_q;
    assign load_weight  = lw_q;
    assign load_input   = li_q;
    assign compute_en   = ce_q;
    assign store_req    = st_q;
    assign busy         = (state_q != S_IDLE) && (state_q != S_HALTED);
    assign done         = done_q;
`ifdef SEQ_ILLEGAL_TRAP_EN
    assign error        = err_q;
`else
    assign error        = 1'b0;
`endif

endmodule

// File: tb/tb_tpu_sequencer.sv
// Directed bench for tpu_sequencer: instruction memory model plus a strobe scoreboard.
module tb_tpu_sequencer;

    localparam int INSTR_W   = 16;
    localparam int ADDR_W    = 13;
    localparam int PC_W      = 8;
    localparam int ARRAY_DIM = 4;
    localparam int CNT_W     = 8;
    localparam int ROW_W     = 2;

    localparam logic [2:0] K_NONE = 3'd0;
    localparam logic [2:0] K_LW   = 3'd1;
    localparam logic [2:0] K_LI   = 3'd2;
    localparam logic [2:0] K_CE   = 3'd3;
    localparam logic [2:0] K_ST   = 3'd4;
    localparam logic [2:0] K_MULT = 3'd7;

    logic               clk;
    logic               reset;
    logic               start;
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instruction;
    logic [ADDR_W-1:0]  base_address;
    logic [ADDR_W-1:0]  mem_addr;
    logic [ROW_W-1:0]   row_idx;
    logic               load_weight;
    logic               load_input;
    logic               compute_en;
    logic               store_req;
    logic               store_ack;
    logic               busy;
    logic               done;
    logic               error;

    tpu_sequencer #(
        .INSTR_W   (INSTR_W),
        .ADDR_W    (ADDR_W),
        .PC_W      (PC_W),
        .ARRAY_DIM (ARRAY_DIM),
        .CNT_W     (CNT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .pc           (pc),
        .instruction  (instruction),
        .base_address (base_address),
        .mem_addr     (mem_addr),
        .row_idx      (row_idx),
        .load_weight  (load_weight),
        .load_input   (load_input),
        .compute_en   (compute_en),
        .store_req    (store_req),
        .store_ack    (store_ack),
        .busy         (busy),
        .done         (done),
        .error        (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [INSTR_W-1:0] imem [2**PC_W];
    always @(posedge clk) instruction <= imem[pc];

    typedef struct {
        logic [2:0]        kind;
        logic [ADDR_W-1:0] addr;
        logic [ROW_W-1:0]  row;
    } sb_t;

    sb_t               sbq[$];
    int                checks;
    int                errors;
    int                ack_delay;
    bit                spur_en;
    logic [ADDR_W-1:0] exp_base;
    int                lat;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] strobe_code();
        int n;
        n = int'(load_weight) + int'(load_input) + int'(compute_en) + int'(store_req);
        if (n > 1)       return K_MULT;
        if (load_weight) return K_LW;
        if (load_input)  return K_LI;
        if (compute_en)  return K_CE;
        if (store_req)   return K_ST;
        return K_NONE;
    endfunction

    function automatic logic [63:0] all_outputs();
        return 64'({pc, base_address, mem_addr, row_idx, load_weight, load_input,
                    compute_en, store_req, busy, done, error});
    endfunction

    task automatic push_rows(input logic [2:0] kind);
        sb_t e;
        for (int r = 0; r < ARRAY_DIM; r++) begin
            e.kind = kind;
            e.addr = exp_base + ADDR_W'(r);
            e.row  = ROW_W'(r);
            sbq.push_back(e);
        end
    endtask

    task automatic push_n(input logic [2:0] kind, input int n);
        sb_t e;
        for (int i = 0; i < n; i++) begin
            e.kind = kind;
            e.addr = exp_base;
            e.row  = '0;
            sbq.push_back(e);
        end
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 2**PC_W; i++) imem[i] = '0;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Starts the program and checks every strobe cycle against the queue until done.
    task automatic run_prog(input int budget, output int latency);
        sb_t        e;
        logic [2:0] code;
        int         req_cyc;
        req_cyc = 0;
        latency = -1;
        pulse_start();
        chk("start_state", 64'({done, error, busy}), 64'(3'b001));
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            code = strobe_code();
            if (code != K_NONE) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_strobe", 64'(code), 64'(K_NONE));
                end else begin
                    e = sbq.pop_front();
                    chk("strobe_kind", 64'(code), 64'(e.kind));
                    chk("mem_addr", 64'(mem_addr), 64'(e.addr));
                    chk("row_idx", 64'(row_idx), 64'(e.row));
                end
            end
            if (store_req) begin
                req_cyc++;
                store_ack = (req_cyc == ack_delay + 1);
            end else begin
                req_cyc = 0;
                store_ack = spur_en && (pc == '0);
            end
            if (done) begin
                latency = k - 1;
                break;
            end
        end
        store_ack = 1'b0;
        chk("done_reached", 64'(done), 64'(1));
        chk("sb_drained", 64'(sbq.size()), 64'(0));
        sbq.delete();
    endtask

    initial begin
        int li_seen;
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        start     = 1'b0;
        store_ack = 1'b0;
        ack_delay = 0;
        spur_en   = 1'b0;
        exp_base  = '0;
        clear_prog();

        #12;
        chk("reset_outputs", all_outputs(), 64'(0));
        @(negedge clk);
        reset = 1'b0;

        // LOAD_ADDR 5, HALT
        imem[0] = 16'h2005;
        imem[1] = 16'hE000;
        run_prog(50, lat);
        chk("t1_latency", 64'(lat), 64'(4));
        chk("t1_base", 64'(base_address), 64'(5));
        chk("t1_pc", 64'(pc), 64'(1));
        chk("t1_busy", 64'(busy), 64'(0));

        // Load phases and two compute lengths, including N=0
        clear_prog();
        imem[0] = 16'h2010;
        imem[1] = 16'h4000;
        imem[2] = 16'h6000;
        imem[3] = 16'h8003;
        imem[4] = 16'h8000;
        imem[5] = 16'hE000;
        exp_base = 13'h0010;
        push_rows(K_LW);
        push_rows(K_LI);
        push_n(K_CE, 3);
        push_n(K_CE, 1);
        run_prog(100, lat);
        chk("t2_latency", 64'(lat), 64'(24));
        chk("t2_pc", 64'(pc), 64'(5));

        // mem_addr wraps past 0x1FFF
        clear_prog();
        imem[0] = 16'h3FFE;
        imem[1] = 16'h4000;
        imem[2] = 16'hE000;
        exp_base = 13'h1FFE;
        push_rows(K_LW);
        run_prog(50, lat);
        chk("t3_latency", 64'(lat), 64'(10));

        // STORE with ack after 5 cycles and a spurious ack while fetching pc 0
        clear_prog();
        imem[0] = 16'h0000;
        imem[1] = 16'hA000;
        imem[2] = 16'hE000;
        ack_delay = 5;
        spur_en   = 1'b1;
        push_n(K_ST, 6);
        run_prog(60, lat);
        chk("t4_latency", 64'(lat), 64'(12));
        chk("t4_pc", 64'(pc), 64'(2));

        // STORE acknowledged on its first cycle
        ack_delay = 0;
        spur_en   = 1'b0;
        push_n(K_ST, 1);
        run_prog(60, lat);
        chk("t5_latency", 64'(lat), 64'(7));
        chk("t5_pc", 64'(pc), 64'(2));

        // Reset during the second load_input cycle, then rerun from pc 0
        clear_prog();
        imem[0] = 16'h6000;
        imem[1] = 16'hE000;
        pulse_start();
        li_seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (load_input) li_seen++;
            if (li_seen == 2) break;
        end
        chk("t6_li_reached", 64'(li_seen), 64'(2));
        reset = 1'b1;
        #1;
        chk("t6_reset_outputs", all_outputs(), 64'(0));
        @(negedge clk);
        reset = 1'b0;
        exp_base = '0;
        push_rows(K_LI);
        run_prog(50, lat);
        chk("t6_latency", 64'(lat), 64'(8));
        chk("t6_pc", 64'(pc), 64'(1));

        // pc wraps 255 -> 0; HALT is placed at 0 once execution has moved past it
        clear_prog();
        pulse_start();
        lat = -1;
        for (int k = 1; k <= 1200; k++) begin
            @(negedge clk);
            if (pc != '0) imem[0] = 16'hE000;
            if (done) begin
                lat = k - 1;
                break;
            end
        end
        chk("t7_latency", 64'(lat), 64'(514));
        chk("t7_pc", 64'(pc), 64'(0));

        // Reserved opcode 110
        clear_prog();
        imem[0] = 16'h0000;
        imem[1] = 16'hC000;
        imem[2] = 16'h2009;
        imem[3] = 16'hE000;
        for (int pass = 0; pass < 2; pass++) begin
            run_prog(50, lat);
`ifdef SEQ_ILLEGAL_TRAP_EN
            chk("t8_latency", 64'(lat), 64'(4));
            chk("t8_error", 64'(error), 64'(1));
            chk("t8_pc", 64'(pc), 64'(1));
            chk("t8_base", 64'(base_address), 64'(0));
`else
            chk("t8_latency", 64'(lat), 64'(8));
            chk("t8_error", 64'(error), 64'(0));
            chk("t8_pc", 64'(pc), 64'(3));
            chk("t8_base", 64'(base_address), 64'(9));
`endif
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
